// File: rtl/vec_op_sequencer.sv
// Vector datapath sequencer: fills memories A/B from UART bytes, reads them back, and streams sum/avg/Manhattan distance.
// States: IDLE wait op | WR rx byte -> mem | RD_ADDR/RD_WAIT fetch element | TX_BYTE/TX_WAIT send result bytes | DONE pulse
module vec_op_sequencer #(
   parameter int N_ELEMS = 1024,
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = $clog2(N_ELEMS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        op,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we_a,
   output logic              mem_we_b,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata_a,
   input  logic [DATA_W-1:0] mem_rdata_b,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_busy,
   output logic              op_finished
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD_ADDR, S_RD_WAIT, S_TX_BYTE, S_TX_WAIT, S_DONE
   } state_t;

   localparam int                ACC_W = 8 + ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_ELEMS - 1);

   state_t              state_q, state_d;
   logic [7:0]          op_q, op_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [23:0]         res_q, res_d;
   logic [1:0]          nb_q, nb_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_we_a_q, mem_we_a_d;
   logic                mem_we_b_q, mem_we_b_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                tx_start_q, tx_start_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic                op_finished_q, op_finished_d;

   logic [8:0]          sum;
   logic [7:0]          diff;
   logic [ACC_W-1:0]    acc_nxt;
   logic [7:0]          cur_byte;

   assign sum     = {1'b0, mem_rdata_a} + {1'b0, mem_rdata_b};
   assign diff    = (mem_rdata_a >= mem_rdata_b) ? (mem_rdata_a - mem_rdata_b)
                                                 : (mem_rdata_b - mem_rdata_a);
   assign acc_nxt = acc_q + ACC_W'(diff);

   // nb_q counts bytes still to send; the highest remaining byte goes out first
   always_comb begin
      case (nb_q)
         2'd3:    cur_byte = res_q[23:16];
         2'd2:    cur_byte = res_q[15:8];
         default: cur_byte = res_q[7:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         idx_q         <= '0;
         acc_q         <= '0;
         res_q         <= '0;
         nb_q          <= '0;
         mem_addr_q    <= '0;
         mem_we_a_q    <= 1'b0;
         mem_we_b_q    <= 1'b0;
         mem_wdata_q   <= '0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         op_finished_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         idx_q         <= idx_d;
         acc_q         <= acc_d;
         res_q         <= res_d;
         nb_q          <= nb_d;
         mem_addr_q    <= mem_addr_d;
         mem_we_a_q    <= mem_we_a_d;
         mem_we_b_q    <= mem_we_b_d;
         mem_wdata_q   <= mem_wdata_d;
         tx_start_q    <= tx_start_d;
         tx_data_q     <= tx_data_d;
         op_finished_q <= op_finished_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      res_d   = res_q;
      nb_d    = nb_q;
      case (state_q)
         S_IDLE: begin
            if (op != 8'd0 && !op_finished_q) begin
               op_d  = op;
               idx_d = '0;
               acc_d = '0;
               if (op == 8'd97 || op == 8'd98)       state_d = S_WR;
               else if (op >= 8'd99 && op <= 8'd103) state_d = S_RD_ADDR;
               else                                  state_d = S_DONE;
            end
         end
         S_WR: begin
            if (rx_valid) begin
               if (idx_q == LAST) state_d = S_DONE;
               else               idx_d   = idx_q + ADDR_W'(1);
            end
         end
         S_RD_ADDR: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            state_d = S_TX_BYTE;
            nb_d    = 2'd1;
            case (op_q)
               8'd99:  res_d = 24'(mem_rdata_a);
               8'd100: res_d = 24'(mem_rdata_b);
               8'd101: begin
                  res_d = 24'(sum);
                  nb_d  = 2'd2;
               end
               8'd102: res_d = 24'(sum[8:1]);
               default: begin
                  acc_d = acc_nxt;
                  if (idx_q == LAST) begin
                     res_d = 24'(acc_nxt);
                     nb_d  = 2'd3;
                  end else begin
                     idx_d   = idx_q + ADDR_W'(1);
                     state_d = S_RD_ADDR;
                  end
               end
            endcase
         end
         S_TX_BYTE: begin
            if (!tx_busy) begin
               nb_d    = nb_q - 2'd1;
               state_d = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            // tx_busy only rises the cycle after tx_start, so the pulse itself must have cleared first
            if (!tx_start_q && !tx_busy) begin
               if (nb_q != 2'd0) begin
                  state_d = S_TX_BYTE;
               end else if (op_q != 8'd103 && idx_q != LAST) begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_RD_ADDR;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_addr_d    = idx_d;
      mem_we_a_d    = 1'b0;
      mem_we_b_d    = 1'b0;
      mem_wdata_d   = mem_wdata_q;
      tx_start_d    = 1'b0;
      tx_data_d     = tx_data_q;
      op_finished_d = 1'b0;
      case (state_q)
         S_WR: begin
            if (rx_valid) begin
               mem_addr_d  = idx_q;
               mem_we_a_d  = (op_q == 8'd97);
               mem_we_b_d  = (op_q == 8'd98);
               mem_wdata_d = rx_data;
            end
         end
         S_TX_BYTE: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = cur_byte;
            end
         end
         S_DONE:  op_finished_d = 1'b1;
         default: ;
      endcase
   end

   assign mem_addr    = mem_addr_q;
   assign mem_we_a    = mem_we_a_q;
   assign mem_we_b    = mem_we_b_q;
   assign mem_wdata   = mem_wdata_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign op_finished = op_finished_q;

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Self-checking bench for vec_op_sequencer: memory and UART TX models, write/tx scoreboards.
module tb_vec_op_sequencer;
   localparam int N  = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [7:0]    op = 8'd0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic [AW-1:0] mem_addr;
   logic          mem_we_a, mem_we_b;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata_a = 8'd0, mem_rdata_b = 8'd0;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_busy;
   logic          op_finished;

   vec_op_sequencer #(.N_ELEMS(N)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .rx_valid(rx_valid), .rx_data(rx_data),
      .mem_addr(mem_addr), .mem_we_a(mem_we_a), .mem_we_b(mem_we_b), .mem_wdata(mem_wdata),
      .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .op_finished(op_finished)
   );

   always #5 clk = ~clk;

   logic [7:0] mem_a [N];
   logic [7:0] mem_b [N];
   logic [7:0] exp_a [N];
   logic [7:0] exp_b [N];
   int         busy_cnt = 0;

   assign tx_busy = (busy_cnt != 0);

   always @(posedge clk) begin
      if (mem_we_a) mem_a[mem_addr] <= mem_wdata;
      if (mem_we_b) mem_b[mem_addr] <= mem_wdata;
      mem_rdata_a <= mem_a[mem_addr];
      mem_rdata_b <= mem_b[mem_addr];
      if (tx_start)          busy_cnt <= 5;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [31:0] wq [$];
   logic [7:0]  tq [$];
   int          fin_cnt = 0;

   function automatic logic [31:0] pack_wr(input logic a, input logic b, input logic [AW-1:0] ad,
                                           input logic [7:0] d);
      return 32'({a, b, ad, d});
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (op_finished) fin_cnt++;
         if (mem_we_a || mem_we_b) begin
            if (wq.size() == 0) chk("wr_unexpected", pack_wr(mem_we_a, mem_we_b, mem_addr, mem_wdata), 32'hFFFF_FFFF);
            else                chk("wr", pack_wr(mem_we_a, mem_we_b, mem_addr, mem_wdata), wq.pop_front());
         end
         if (tx_start) begin
            chk("tx_while_busy", 32'(tx_busy), 32'd0);
            if (tq.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            else                chk("tx_byte", 32'(tx_data), 32'(tq.pop_front()));
         end
      end
   end

   task automatic chk_outputs_zero();
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_we_a", 32'(mem_we_a), 32'd0);
      chk("rst_we_b", 32'(mem_we_b), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_op_finished", 32'(op_finished), 32'd0);
   endtask

   task automatic wait_fin(input int limit, output int cyc);
      cyc = 0;
      while (!op_finished && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      chk("fin_seen", 32'(op_finished), 32'd1);
      chk("fin_tx_idle", 32'(tx_busy), 32'd0);
      op = 8'd0;
      @(negedge clk);
      chk("fin_one_cycle", 32'(op_finished), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] opc, input int i, input logic [7:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      wq.push_back(pack_wr(opc == 8'd97, opc == 8'd98, AW'(i), d));
      if (opc == 8'd97) exp_a[i] = d;
      else              exp_b[i] = d;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic write_vec(input logic [7:0] opc, input logic [31:0] bytes);
      int cyc;
      @(negedge clk);
      op = opc;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         send_byte(opc, i, bytes[8*i +: 8]);
         if (i < N - 1) @(negedge clk);
      end
      wait_fin(50, cyc);
      chk("wr_q_drained", 32'(wq.size()), 32'd0);
   endtask

   task automatic run_rd(input logic [7:0] opc);
      logic [8:0]  s;
      logic [23:0] acc;
      int          cyc;
      acc = 24'd0;
      for (int i = 0; i < N; i++) begin
         s = {1'b0, exp_a[i]} + {1'b0, exp_b[i]};
         case (opc)
            8'd99:  tq.push_back(exp_a[i]);
            8'd100: tq.push_back(exp_b[i]);
            8'd101: begin
               tq.push_back({7'd0, s[8]});
               tq.push_back(s[7:0]);
            end
            8'd102: tq.push_back(s[8:1]);
            default: acc = acc + ((exp_a[i] >= exp_b[i]) ? 24'(exp_a[i] - exp_b[i])
                                                         : 24'(exp_b[i] - exp_a[i]));
         endcase
      end
      if (opc == 8'd103) begin
         tq.push_back(acc[23:16]);
         tq.push_back(acc[15:8]);
         tq.push_back(acc[7:0]);
      end
      @(negedge clk);
      op = opc;
      wait_fin(500, cyc);
      chk("tx_q_drained", 32'(tq.size()), 32'd0);
   endtask

   initial begin
      int fin_before;
      int cyc;
      for (int i = 0; i < N; i++) begin
         mem_a[i] = 8'd0; mem_b[i] = 8'd0; exp_a[i] = 8'd0; exp_b[i] = 8'd0;
      end
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_outputs_zero();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // abort a write after two bytes
      op = 8'd97;
      @(negedge clk);
      send_byte(8'd97, 0, 8'd1);
      @(negedge clk);
      send_byte(8'd97, 1, 8'd2);
      @(negedge clk);
      fin_before = fin_cnt;
      rst_n = 1'b0;
      op    = 8'd0;
      #1;
      chk_outputs_zero();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_fin_after_abort", 32'(fin_cnt), 32'(fin_before));
      chk("abort_wr_q_drained", 32'(wq.size()), 32'd0);

      write_vec(8'd97, {8'd40, 8'd30, 8'd20, 8'd10});
      write_vec(8'd98, {8'd1, 8'd30, 8'd5, 8'd250});
      chk("mem_a_retained", 32'(mem_a[0]), 32'd10);

      run_rd(8'd99);
      run_rd(8'd100);
      run_rd(8'd101);
      run_rd(8'd102);
      run_rd(8'd103);

      fin_before = fin_cnt;
      @(negedge clk);
      op = 8'd55;
      wait_fin(2, cyc);
      chk("invalid_fin_count", 32'(fin_cnt), 32'(fin_before + 1));
      repeat (3) @(negedge clk);
      chk("invalid_no_extra_fin", 32'(fin_cnt), 32'(fin_before + 1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/vec_op_sequencer.md
Name: vec_op_sequencer

Overview:
Sequences the vector datapath for the UART coprocessor once the command decoder has issued an opcode. It fills the vector memories A and B from received UART bytes and reads them back. It also computes element-wise sum, element-wise average or Manhattan distance and streams results to the UART transmitter. It pulses op_finished on completion so the command decoder returns to idle.

Parameters:
N_ELEMS, 1024, number of elements per vector (power of two, >=2)
DATA_W, 8, element width in bits (fixed to 8 in this design; one UART byte per element)
ADDR_W, $clog2(N_ELEMS), memory address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  8  opcode from command decoder: 0 idle, 97 writeVec_A, 98 writeVec_B, 99 readVec_A, 100 readVec_B, 101 sumVec, 102 avgVec, 103 manDist; held stable until op_finished
rx_valid  in  1  one-cycle pulse, new UART byte on rx_data
rx_data  in  8  received byte
mem_addr  out  ADDR_W  shared address to vector memories A and B
mem_we_a  out  1  write enable, memory A
mem_we_b  out  1  write enable, memory B
mem_wdata  out  8  write data (shared)
mem_rdata_a  in  8  memory A read data, valid 1 cycle after mem_addr
mem_rdata_b  in  8  memory B read data, valid 1 cycle after mem_addr
tx_start  out  1  one-cycle pulse, send tx_data
tx_data  out  8  byte to transmit
tx_busy  in  1  transmitter busy; rises the cycle after tx_start, low when ready
op_finished  out  1  one-cycle pulse, operation complete

Behaviour:
- Reset (async, rst_n low): state IDLE. mem_addr, mem_we_a, mem_we_b, mem_wdata, tx_start, tx_data and op_finished are all 0. Element index 0, accumulator 0.
- State encoding: IDLE, WR, RD_ADDR, RD_WAIT, TX_BYTE, TX_WAIT, DONE.
- IDLE: when op != 0, latch op and clear the index and accumulator on the next edge.
  - Opcodes 97/98 go to WR; 99–103 go to RD_ADDR.
  - Any other nonzero opcode goes straight to DONE, so the decoder is never stuck.
- WR: each rx_valid writes rx_data to index i for one cycle, with mem_we_a for op 97 or mem_we_b for op 98, and mem_addr=i; then i increments.
  - After the write at i=N_ELEMS-1, go to DONE.
  - Bytes arriving in any other state are ignored.
- RD_ADDR: drive mem_addr=i, then RD_WAIT (one cycle of memory latency). In RD_WAIT, capture rdata into the result register:
  - op 99: result = A[i], 1 byte.
  - op 100: result = B[i], 1 byte.
  - op 101: result = A[i]+B[i], 9 bits, sent as 2 bytes, high byte (0 or 1) first.
  - op 102: result = (A[i]+B[i])>>1, 9-bit sum truncated toward zero, 1 byte.
  - op 103: acc += |A[i]-B[i]|. acc is 8+ADDR_W bits, cannot overflow. No transmit per element. If i<N_ELEMS-1, increment i and go to RD_ADDR; else load acc as result, 3 bytes MSB first, zero-padded to 24 bits.
- TX_BYTE: wait until tx_busy==0, then assert tx_start for exactly one cycle with tx_data = current byte. Go to TX_WAIT, which holds at least one cycle and then until tx_busy==0.
  - If more bytes of the current result remain, return to TX_BYTE.
  - Otherwise, for element ops with i<N_ELEMS-1, increment i and go to RD_ADDR.
  - Otherwise go to DONE.
- DONE: op_finished=1 for one cycle, then IDLE. IDLE ignores op while op_finished is high, which avoids a re-trigger in the same cycle.
- Read-op throughput: one element per transmitted frame; memory latency overlaps no transmit.
- Index wrap: the index never exceeds N_ELEMS-1 and is cleared on entry from IDLE.
- Reset mid-operation: aborts immediately. No op_finished is issued, and partially written memory contents are retained.
- rx_valid coinciding with the state transition out of IDLE is not captured. The first element must arrive at least 1 cycle after op is applied.

Test Plan (bench N_ELEMS=4, tx model busy 5 cycles after each tx_start):
1. Reset mid-WR after 2 bytes -> all outputs 0 immediately. Re-issue op 97 -> index restarts at 0, first write to addr 0.
2. op=97, rx bytes 10,20,30,40 -> writes A[0..3]=10,20,30,40 with mem_we_a only, one op_finished pulse after the 4th. Repeat op=98 with 250,5,30,1 -> B written.
3. op=99 -> tx bytes 10,20,30,40 in order, tx_start never while tx_busy=1, op_finished after the last tx completes.
4. op=101 -> tx 0x01,0x04, 0x00,0x19, 0x00,0x3C, 0x00,0x29 (260,25,60,41). op=102 -> tx 130,12,30,20.
5. op=103 -> |10-250|+|20-5|+0+|40-1|=294 -> tx 0x00,0x01,0x26.
6. op=55 (invalid) -> op_finished pulse within 2 cycles, no tx_start, no memory write.
